frame_render_scheduler: RTL

//  Per-frame sequencer and VGA-port arbiter for the Pong render datapath.
//  On each frame_tick it runs the erase/redraw jobs in a fixed order: paddle 1, paddle 2, ball.
//  For each job it issues the start pulse, waits for the done handshake, and owns the single VGA plot port.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/render_wait_timer.sv | 39 +++
 rtl/frame_render_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong render path: scheduler state encoding,
// coordinate width helpers and the colour constants.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_P1_GO   = 3'd1,
        ST_P1_WAIT = 3'd2,
        ST_P2_GO   = 3'd3,
        ST_P2_WAIT = 3'd4,
        ST_B_GO    = 3'd5,
        ST_B_WAIT  = 3'd6
    } sched_state_e;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    function automatic int x_w(input int screen_x);
        return $clog2(screen_x) + 1;
    endfunction

    function automatic int y_w(input int screen_y);
        return $clog2(screen_y) + 1;
    endfunction

endpackage

// File: rtl/render_wait_timer.sv
// Watchdog counter for a render job: cleared on load, counts while a job is
// pending and flags expiry once it has sat on the last count.
module render_wait_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable_i,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && cnt_q != LAST) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/frame_render_scheduler.sv
// Per-frame sequencer for the Pong renderers: runs paddle 1, paddle 2 and
// ball jobs in order and arbitrates the single VGA plot port between them.
module frame_render_scheduler
    import pong_pkg::*;
#(
    parameter int SCREEN_X = 640,
    parameter int SCREEN_Y = 480,
    parameter int TIMEOUT  = 4096,
    localparam int X_W = x_w(SCREEN_X),
    localparam int Y_W = y_w(SCREEN_Y)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           frame_tick,
    output logic           pulse_clear1,
    output logic           pulse_clear2,
    output logic           ball_start,
    input  logic           done_draw1,
    input  logic           done_draw2,
    input  logic           ball_done,
    input  logic [X_W-1:0] pad_x,
    input  logic [Y_W-1:0] pad_y,
    input  logic [2:0]     pad_col,
    input  logic [X_W-1:0] ball_x,
    input  logic [Y_W-1:0] ball_y,
    input  logic [2:0]     ball_col,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_col,
    output logic           plot,
    output logic           busy,
    output logic           overrun,
    output logic           timeout_err
);

    sched_state_e   state_q, state_d;
    logic           pend_q, pend_d;
    logic           overrun_q, overrun_d;
    logic           tout_q, tout_d;
    logic           pulse1_q, pulse1_d;
    logic           pulse2_q, pulse2_d;
    logic           pulseb_q, pulseb_d;
    logic [X_W-1:0] vga_x_q, vga_x_d;
    logic [Y_W-1:0] vga_y_q, vga_y_d;
    logic [2:0]     vga_col_q, vga_col_d;
    logic           plot_q, plot_d;

    logic           tmr_load, tmr_count, tmr_expired;
    logic           in_wait, job_done;
    sched_state_e   wait_next;

    render_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .enable_i (enable),
        .load_i   (tmr_load),
        .count_i  (tmr_count),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        overrun_d = overrun_q;
        tout_d    = tout_q;
        pulse1_d  = 1'b0;
        pulse2_d  = 1'b0;
        pulseb_d  = 1'b0;
        vga_x_d   = '0;
        vga_y_d   = '0;
        vga_col_d = COL_BLACK;
        plot_d    = 1'b0;
        tmr_load  = 1'b0;
        tmr_count = 1'b0;
        in_wait   = 1'b0;
        job_done  = 1'b0;
        wait_next = ST_IDLE;

        // A tick during a frame is remembered once; later ones are lost.
        if (frame_tick && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
            pend_d    = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick || pend_q) begin
                    state_d = ST_P1_GO;
                    pend_d  = 1'b0;
                end
            end
            ST_P1_GO: begin
                pulse1_d = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_P1_WAIT;
            end
            ST_P1_WAIT: begin
                in_wait   = 1'b1;
                job_done  = done_draw1;
                wait_next = ST_P2_GO;
                vga_x_d   = pad_x;
                vga_y_d   = pad_y;
                vga_col_d = pad_col;
            end
            ST_P2_GO: begin
                pulse2_d = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_P2_WAIT;
            end
            ST_P2_WAIT: begin
                in_wait   = 1'b1;
                job_done  = done_draw2;
                wait_next = ST_B_GO;
                vga_x_d   = pad_x;
                vga_y_d   = pad_y;
                vga_col_d = pad_col;
            end
            ST_B_GO: begin
                pulseb_d = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_B_WAIT;
            end
            ST_B_WAIT: begin
                in_wait   = 1'b1;
                job_done  = ball_done;
                wait_next = ST_IDLE;
                vga_x_d   = ball_x;
                vga_y_d   = ball_y;
                vga_col_d = ball_col;
            end
            default: state_d = ST_IDLE;
        endcase

        // Done wins over a coincident expiry, so the error flag stays clear.
        if (in_wait) begin
            tmr_count = 1'b1;
            plot_d    = !job_done;
            if (job_done || tmr_expired) begin
                state_d = wait_next;
                if (!job_done) tout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            tout_q    <= 1'b0;
            pulse1_q  <= 1'b0;
            pulse2_q  <= 1'b0;
            pulseb_q  <= 1'b0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= COL_BLACK;
            plot_q    <= 1'b0;
        end else if (enable) begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            tout_q    <= tout_d;
            pulse1_q  <= pulse1_d;
            pulse2_q  <= pulse2_d;
            pulseb_q  <= pulseb_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
            plot_q    <= plot_d;
        end
    end

    assign pulse_clear1 = pulse1_q;
    assign pulse_clear2 = pulse2_q;
    assign ball_start   = pulseb_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_col      = vga_col_q;
    assign plot         = plot_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;
    assign timeout_err  = tout_q;

endmodule
